// File: rtl/alu_arbiter_if.sv
// Bus bundle between the SoC requesters, the shared-ALU arbiter and the ALU itself.
// ALU_ARB_FLAGS_EN adds the rsp_zero / rsp_carry response flags.
`default_nettype none

`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 8
`endif

interface alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = `DATA_BUS_LEN
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [3*NUM_REQ-1:0]  req_op;
    logic [DW*NUM_REQ-1:0] req_var1;
    logic [DW*NUM_REQ-1:0] req_var2;

    logic [2:0]            alu_operation;
    logic [DW-1:0]         alu_var1;
    logic [DW-1:0]         alu_var2;
    logic [DW-1:0]         alu_accumulator;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [DW-1:0]         rsp_data;
    logic                  busy;
`ifdef ALU_ARB_FLAGS_EN
    logic                  rsp_zero;
    logic                  rsp_carry;
`endif

    // Requesters plus the ALU model sit on the master side.
    modport master (
        output req_valid, req_op, req_var1, req_var2, alu_accumulator, rsp_ready,
        input  req_ready, alu_operation, alu_var1, alu_var2, rsp_valid, rsp_data, busy
`ifdef ALU_ARB_FLAGS_EN
        , input rsp_zero, rsp_carry
`endif
    );

    modport slave (
        input  req_valid, req_op, req_var1, req_var2, alu_accumulator, rsp_ready,
        output req_ready, alu_operation, alu_var1, alu_var2, rsp_valid, rsp_data, busy
`ifdef ALU_ARB_FLAGS_EN
        , output rsp_zero, rsp_carry
`endif
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Function : round-robin sharing of one combinational ALU among NUM_REQ
//            requesters; optional result flags under macro ALU_ARB_FLAGS_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_BUS_LEN
`define DATA_BUS_LEN 8
`endif

module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = `DATA_BUS_LEN
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_arbiter_if.slave   bus
);

    localparam int              c_iw     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_iw:0]   c_num    = (c_iw+1)'(NUM_REQ);
    localparam logic [c_iw-1:0] c_last   = c_iw'(NUM_REQ - 1);
    localparam logic [2:0]      c_op_add = 3'b000;
    localparam logic [2:0]      c_op_sub = 3'b001;
    localparam logic [2:0]      c_op_nop = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_iw-1:0]     r_ptr;
    logic [c_iw-1:0]     r_gnt;
    logic [2:0]          r_alu_op;
    logic [DW-1:0]       r_alu_var1;
    logic [DW-1:0]       r_alu_var2;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DW-1:0]       r_rsp_data;
    logic                r_busy;

    logic                w_found;
    logic [c_iw-1:0]     w_idx;
    logic [c_iw-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]  w_ready;
    logic [NUM_REQ-1:0]  w_gnt_onehot;
    logic [2:0]          w_sel_op;
    logic [DW-1:0]       w_sel_var1;
    logic [DW-1:0]       w_sel_var2;

    // First valid requester at or after the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        logic [c_iw:0]   w_sum;
        logic [c_iw-1:0] w_j;
        w_found = 1'b0;
        w_idx   = '0;
        w_sum   = '0;
        w_j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (c_iw+1)'(i);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            w_j = w_sum[c_iw-1:0];
            if (!w_found && bus.req_valid[w_j]) begin
                w_found = 1'b1;
                w_idx   = w_j;
            end
        end
    end

    always_comb begin
        w_sel_op   = '0;
        w_sel_var1 = '0;
        w_sel_var2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == c_iw'(i)) begin
                w_sel_op   = bus.req_op[3*i +: 3];
                w_sel_var1 = bus.req_var1[DW*i +: DW];
                w_sel_var2 = bus.req_var2[DW*i +: DW];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if ((r_state == ST_IDLE) && w_found && !rst) begin
            w_ready[w_idx] = 1'b1;
        end
    end

    always_comb begin
        w_gnt_onehot        = '0;
        w_gnt_onehot[r_gnt] = 1'b1;
    end

    assign w_next_ptr = (w_idx == c_last) ? '0 : w_idx + 1'b1;

`ifdef ALU_ARB_FLAGS_EN
    logic          r_rsp_carry;
    logic [DW:0]   w_add_full;
    logic          w_carry;

    // Carry comes from the latched operands, not from the ALU.
    assign w_add_full = {1'b0, r_alu_var1} + {1'b0, r_alu_var2};
    assign w_carry    = (r_alu_op == c_op_add) ? w_add_full[DW] :
                        (r_alu_op == c_op_sub) ? (r_alu_var1 < r_alu_var2) : 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_alu_op    <= c_op_nop;
            r_alu_var1  <= '0;
            r_alu_var2  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
            r_rsp_carry <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_alu_op   <= w_sel_op;
                        r_alu_var1 <= w_sel_var1;
                        r_alu_var2 <= w_sel_var2;
                        r_gnt      <= w_idx;
                        r_ptr      <= w_next_ptr;
                        r_busy     <= 1'b1;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_data  <= bus.alu_accumulator;
                    r_rsp_valid <= w_gnt_onehot;
`ifdef ALU_ARB_FLAGS_EN
                    r_rsp_carry <= w_carry;
`endif
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready[r_gnt]) begin
                        r_rsp_valid <= '0;
                        r_alu_op    <= c_op_nop;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.alu_operation = r_alu_op;
    assign bus.alu_var1      = r_alu_var1;
    assign bus.alu_var2      = r_alu_var2;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.busy          = r_busy;
`ifdef ALU_ARB_FLAGS_EN
    assign bus.rsp_zero      = (r_rsp_data == '0);
    assign bus.rsp_carry     = r_rsp_carry;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural ALU.
`default_nettype none

module tb_alu_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NUM_REQ(NR), .DW(8)) bus ();

    alu_arbiter #(.NUM_REQ(NR), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return b;
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural ALU: op 111 holds the previous result.
    logic [7:0] alu_hold = 8'h00;
    always @(bus.alu_operation or bus.alu_var1 or bus.alu_var2) begin
        if (bus.alu_operation != 3'b111) alu_hold = alu_f(bus.alu_operation, bus.alu_var1, bus.alu_var2);
    end
    assign bus.alu_accumulator = (bus.alu_operation == 3'b111) ? alu_hold
                               : alu_f(bus.alu_operation, bus.alu_var1, bus.alu_var2);

    // Transaction model: phase 0 waiting, 1 operation in flight, 2 response pending.
    int         m_phase = 0;
    int         m_ptr   = 0;
    int         m_g     = 0;
    logic [7:0] m_hold  = 8'h00;
    logic [7:0] m_exp   = 8'h00;
    logic [7:0] m_data  = 8'h00;
    logic       m_exp_c = 1'b0;
    logic       m_carry = 1'b0;
    logic [2:0] m_aop   = 3'b111;
    logic [7:0] m_av1   = 8'h00;
    logic [7:0] m_av2   = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_alu_op", bus.alu_operation, 3'b111);
            chk("rst_alu_var1", bus.alu_var1, 0);
            chk("rst_alu_var2", bus.alu_var2, 0);
            chk("rst_rsp_data", bus.rsp_data, 0);
            m_phase = 0; m_ptr = 0; m_data = 8'h00; m_carry = 1'b0;
            m_aop = 3'b111; m_av1 = 8'h00; m_av2 = 8'h00;
        end else begin
            chk("m_rsp_data", bus.rsp_data, m_data);
            chk("m_alu_op", bus.alu_operation, m_aop);
            chk("m_alu_var1", bus.alu_var1, m_av1);
            chk("m_alu_var2", bus.alu_var2, m_av2);
`ifdef ALU_ARB_FLAGS_EN
            chk("m_rsp_zero", bus.rsp_zero, (m_data == 8'h00));
            chk("m_rsp_carry", bus.rsp_carry, m_carry);
`endif
            if (m_phase == 0) begin
                int w;
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    if (w < 0 && bus.req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                end
                chk("m_idle_ready", bus.req_ready, (w < 0) ? 64'd0 : (64'd1 << w));
                chk("m_idle_rsp_valid", bus.rsp_valid, 0);
                chk("m_idle_busy", bus.busy, 0);
                if (w >= 0) begin
                    logic [7:0] a, b;
                    logic [2:0] op;
                    op = bus.req_op[3*w +: 3];
                    a  = bus.req_var1[8*w +: 8];
                    b  = bus.req_var2[8*w +: 8];
                    if (op == 3'b111) m_exp = m_hold;
                    else begin m_exp = alu_f(op, a, b); m_hold = m_exp; end
                    m_exp_c = (op == 3'd0) ? ((int'(a) + int'(b)) > 255) :
                              (op == 3'd1) ? (a < b) : 1'b0;
                    m_g = w; m_aop = op; m_av1 = a; m_av2 = b;
                    m_ptr = (w + 1) % NR;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                chk("m_exec_ready", bus.req_ready, 0);
                chk("m_exec_rsp_valid", bus.rsp_valid, 0);
                chk("m_exec_busy", bus.busy, 1);
                m_data = m_exp; m_carry = m_exp_c;
                m_phase = 2;
            end else begin
                chk("m_resp_ready", bus.req_ready, 0);
                chk("m_resp_rsp_valid", bus.rsp_valid, 64'd1 << m_g);
                chk("m_resp_busy", bus.busy, 1);
                if (bus.rsp_ready[m_g]) begin
                    m_phase = 0; m_aop = 3'b111;
                end
            end
        end
    end

    task automatic raise(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op[3*i +: 3]  = op;
        bus.req_var1[8*i +: 8] = a;
        bus.req_var2[8*i +: 8] = b;
        bus.req_valid[i]       = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.req_valid = '0; bus.rsp_ready = '1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Lone request from an idle arbiter: READY same cycle, response two cycles on.
    task automatic t_single(input string tag, input int i, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        @(posedge clk); #1; raise(i, op, a, b);
        @(negedge clk); chk({tag, "_ready"}, bus.req_ready, 64'd1 << i);
        @(posedge clk); #1; bus.req_valid[i] = 1'b0;
        @(negedge clk); chk({tag, "_k1_rsp_valid"}, bus.rsp_valid, 0);
        @(negedge clk); chk({tag, "_k2_rsp_valid"}, bus.rsp_valid, 64'd1 << i);
        chk({tag, "_data"}, bus.rsp_data, exp);
    endtask

    task automatic drain(input string tag, input int i, input logic [7:0] exp);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.req_ready[i] !== 1'b1 && n < 20);
        chk({tag, "_ready"}, bus.req_ready, 64'd1 << i);
        @(posedge clk); #1; bus.req_valid[i] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.rsp_valid == '0 && n < 20);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 64'd1 << i);
        chk({tag, "_data"}, bus.rsp_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp2 [4];
        logic [3:0] tx;
        bus.req_valid = '0; bus.req_op = '0; bus.req_var1 = '0; bus.req_var2 = '0;
        bus.rsp_ready = '1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;

        t_single("t1_add", 0, 3'd0, 8'd5, 8'd3, 8'd8);

        // All four at once: grants come out 0,1,2,3 after reset.
        do_reset();
        exp2[0] = 8'h05; exp2[1] = 8'h30; exp2[2] = 8'hAF; exp2[3] = 8'hF0;
        @(posedge clk); #1;
        raise(0, 3'd1, 8'h09, 8'h04);
        raise(1, 3'd2, 8'hF0, 8'h3C);
        raise(2, 3'd3, 8'h0F, 8'hA0);
        raise(3, 3'd4, 8'hFF, 8'h0F);
        for (int n = 0; n < NR; n++) drain($sformatf("t2_rr%0d", n), n, exp2[n]);

        t_single("t3_sub", 1, 3'd1, 8'h00, 8'h01, 8'hFF);
`ifdef ALU_ARB_FLAGS_EN
        chk("t3_carry", bus.rsp_carry, 1);
        chk("t3_zero", bus.rsp_zero, 0);
`endif

        // Stalled response: everything holds while requester 0 waits.
        bus.rsp_ready = 4'b1011;
        @(posedge clk); #1; raise(2, 3'd0, 8'd7, 8'd9);
        @(negedge clk); chk("t4_ready", bus.req_ready, 4'b0100);
        @(posedge clk); #1; bus.req_valid[2] = 1'b0; raise(0, 3'd4, 8'h55, 8'hAA);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_hold_rsp_valid", bus.rsp_valid, 4'b0100);
            chk("t4_hold_data", bus.rsp_data, 8'h10);
            chk("t4_hold_ready", bus.req_ready, 0);
            chk("t4_hold_busy", bus.busy, 1);
        end
        @(posedge clk); #1; bus.rsp_ready = '1;
        drain("t4_next", 0, 8'hFF);

        // Reset in EXEC drops the operation.
        @(posedge clk); #1; raise(3, 3'd0, 8'd1, 8'd1);
        @(negedge clk); chk("t5_ready", bus.req_ready, 4'b1000);
        @(posedge clk); #1; bus.req_valid[3] = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t5_alu_op", bus.alu_operation, 3'b111);
        chk("t5_busy", bus.busy, 0);
        chk("t5_rsp_data", bus.rsp_data, 0);
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); chk("t5_no_rsp", bus.rsp_valid, 0);
        end

        t_single("t6_add", 0, 3'd0, 8'd2, 8'd2, 8'd4);
        @(negedge clk); chk("t6_idle_op", bus.alu_operation, 3'b111);
        t_single("t6_nop", 1, 3'b111, 8'h12, 8'h34, 8'd4);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); tx = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 999) < 3) rst = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (tx[i] || !bus.req_valid[i]) begin
                    if ($urandom_range(0, 99) < 40) begin
                        logic [7:0] a, b;
                        a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                        b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                        raise(i, 3'($urandom_range(0, 7)), a, b);
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1; rst = 1'b0; bus.req_valid = '0; bus.rsp_ready = '1;
        repeat (10) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
